// File: rtl/isched_fetch_ctrl.sv
// isched_fetch_ctrl: row fetch sequencer with a 2-row buffer.
// Each buffered row is issued as four instructions over valid/ready.
module isched_fetch_ctrl #(
   parameter int DATA_W = 192,
   parameter int INST_W = 48,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_rows,
   input  logic              abort,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [1:0]        inst_slot,
   output logic [ADDR_W-1:0] inst_row,
   output logic              busy,
   output logic              done
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [ADDR_W:0] ONE = 1;

   state_t            state, state_nx;
   logic [DATA_W-1:0] row_buf [2];
   logic [ADDR_W-1:0] row_adr [2];
   logic              wr_ptr, rd_ptr;
   logic [1:0]        fifo_cnt, fifo_cnt_nx;
   logic              cap;
   logic [ADDR_W-1:0] cap_addr;
   logic [ADDR_W-1:0] run_base;
   logic [ADDR_W:0]   run_rows, req_cnt, pop_cnt;
   logic [1:0]        slot;
   logic              xfer, pop, last_pop;
   logic              launch, empty_launch, issue;
   logic [DATA_W-1:0] head;

   assign inst_valid   = (fifo_cnt != 2'd0);
   assign head         = row_buf[rd_ptr];
   assign inst_row     = row_adr[rd_ptr];
   assign inst_slot    = slot;
   assign busy         = (state == RUN);
   assign xfer         = inst_valid & inst_ready;
   assign pop          = xfer & (slot == 2'd3);
   assign last_pop     = pop & ((pop_cnt + ONE) == run_rows);
   assign launch       = start & ~abort & (state == IDLE)
                         & (num_rows != '0);
   assign empty_launch = start & ~abort & (state == IDLE)
                         & (num_rows == '0);
   assign fifo_cnt_nx  = fifo_cnt + {1'b0, cap} - {1'b0, pop};
   assign issue        = (state == RUN) & ~last_pop
                         & (req_cnt < run_rows)
                         & (({1'b0, fifo_cnt_nx} + {2'b0, mem_rd}) < 3'd2);

   // Head-row slice for the current slot; slot 0 is the top word.
   always_comb begin
      inst_data = head[INST_W-1:0];
      case (slot)
         2'd0:    inst_data = head[4*INST_W-1 -: INST_W];
         2'd1:    inst_data = head[3*INST_W-1 -: INST_W];
         2'd2:    inst_data = head[2*INST_W-1 -: INST_W];
         default: inst_data = head[INST_W-1:0];
      endcase
   end

   // Next-state logic: abort always wins, last pop ends the run.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (launch) state_nx = RUN;
         RUN:     if (abort || last_pop) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Fetch credits, row buffer, slot counter and done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            row_buf[i] <= '0;
            row_adr[i] <= '0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
         cap      <= 1'b0;
         cap_addr <= '0;
         run_base <= '0;
         run_rows <= '0;
         req_cnt  <= '0;
         pop_cnt  <= '0;
         slot     <= 2'd0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         done     <= 1'b0;
      end else if (abort) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
         cap      <= 1'b0;
         req_cnt  <= '0;
         pop_cnt  <= '0;
         slot     <= 2'd0;
         mem_rd   <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= empty_launch | last_pop;
         cap      <= mem_rd;
         cap_addr <= mem_addr;
         fifo_cnt <= fifo_cnt_nx;
         if (cap) begin
            row_buf[wr_ptr] <= mem_data;
            row_adr[wr_ptr] <= cap_addr;
            wr_ptr          <= ~wr_ptr;
         end
         if (xfer) slot <= slot + 2'd1;
         if (pop) begin
            rd_ptr  <= ~rd_ptr;
            pop_cnt <= pop_cnt + ONE;
         end
         mem_rd <= launch | issue;
         if (launch) begin
            run_base <= base_addr;
            run_rows <= num_rows;
            req_cnt  <= ONE;
            pop_cnt  <= '0;
            mem_addr <= base_addr;
         end else if (issue) begin
            req_cnt  <= req_cnt + ONE;
            mem_addr <= run_base + req_cnt[ADDR_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_isched_fetch_ctrl.sv
// tb_isched_fetch_ctrl: table-driven and random runs against a
// queue-based reference of the expected instruction stream.
module tb_isched_fetch_ctrl;
   logic         clock, reset, start, abort;
   logic [7:0]   base_addr;
   logic [8:0]   num_rows;
   logic         mem_rd;
   logic [7:0]   mem_addr;
   logic [191:0] mem_data;
   logic         inst_valid, inst_ready;
   logic [47:0]  inst_data;
   logic [1:0]   inst_slot;
   logic [7:0]   inst_row;
   logic         busy, done;

   isched_fetch_ctrl dut (
      .clock(clock), .reset(reset), .start(start),
      .base_addr(base_addr), .num_rows(num_rows), .abort(abort),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_slot(inst_slot),
      .inst_row(inst_row), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [47:0] d;
      logic [1:0]  s;
      logic [7:0]  r;
   } item_t;

   typedef struct {
      logic [7:0] base;
      int         rows;
      int         pct;
      bit         poke;
      int         exp_xfers;
      int         exp_reads;
   } vec_t;

   logic [191:0] mem [256];
   item_t        exp_q[$];
   int           n_chk = 0;
   int           n_fail = 0;
   bit           mon_en = 0;
   bit           active = 0;
   bit           exp_done = 0;
   bit           prev_stall = 0;
   logic [47:0]  h_d;
   logic [1:0]   h_s;
   logic [7:0]   h_r;
   logic [7:0]   m_base;
   int           m_rows, reads, xfers, done_cnt;

   initial clock = 0;
   always #5 clock = ~clock;

   // Row memory with one cycle of read latency.
   always @(posedge clock)
      mem_data <= mem_rd ? mem[mem_addr] : '0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Cycle monitor against the expected stream.
   always @(negedge clock) begin
      item_t      it;
      logic [7:0] ea;
      bit         nd;
      if (reset && mon_en) begin
         chk("done", done, exp_done);
         if (done) done_cnt++;
         if (exp_done) chk("busy_at_done", busy, 0);
         nd = 0;
         if (prev_stall) begin
            chk("hold_valid", inst_valid, 1);
            chk("hold_data", inst_data, h_d);
            chk("hold_slot", inst_slot, h_s);
            chk("hold_row", inst_row, h_r);
         end
         if (active) begin
            if (mem_rd) begin
               ea = m_base + 8'(reads);
               chk("mem_addr", mem_addr, ea);
               reads++;
               chk("rd_limit", reads <= m_rows, 1);
            end
            chk("ahead", (reads - xfers / 4) <= 2, 1);
            if (inst_valid && inst_ready) begin
               if (exp_q.size() == 0) chk("extra_xfer", 1, 0);
               else begin
                  it = exp_q.pop_front();
                  chk("inst_data", inst_data, it.d);
                  chk("inst_slot", inst_slot, it.s);
                  chk("inst_row", inst_row, it.r);
               end
               xfers++;
               if (xfers == m_rows * 4) begin
                  nd = 1;
                  active = 0;
               end
            end
         end else chk("idle_rd", mem_rd, 0);
         prev_stall = inst_valid && !inst_ready;
         h_d = inst_data;
         h_s = inst_slot;
         h_r = inst_row;
         exp_done = nd;
      end
   end

   task automatic do_start(input logic [7:0] b, input int rows);
      logic [7:0]   a;
      logic [191:0] row;
      item_t        it;
      m_base = b;
      m_rows = rows;
      reads = 0;
      xfers = 0;
      exp_q.delete();
      for (int r = 0; r < rows; r++) begin
         a = b + 8'(r);
         row = mem[a];
         for (int s = 0; s < 4; s++) begin
            it.d = 48'(row >> ((3 - s) * 48));
            it.s = 2'(s);
            it.r = a;
            exp_q.push_back(it);
         end
      end
      prev_stall = 0;
      exp_done = 0;
      active = (rows != 0);
      mon_en = 1;
      base_addr = b;
      num_rows = 9'(rows);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic run(input vec_t v);
      int d0, k;
      d0 = done_cnt;
      inst_ready = ($urandom_range(99) < v.pct);
      do_start(v.base, v.rows);
      @(negedge clock);
      chk("lat_rd", mem_rd, 1);
      chk("lat_busy", busy, 1);
      @(negedge clock);
      chk("lat_v2", inst_valid, 0);
      @(negedge clock);
      chk("lat_v3", inst_valid, 1);
      k = 0;
      while (done_cnt == d0 && k < v.rows * 80 + 50) begin
         tick();
         inst_ready = ($urandom_range(99) < v.pct);
         start = 0;
         if (v.poke && k == 3) begin
            base_addr = 8'h55;
            num_rows = 9'd7;
            start = 1;
         end
         k++;
      end
      start = 0;
      inst_ready = 0;
      tick();
      tick();
      chk("timeout", done_cnt != d0, 1);
      chk("done_count", done_cnt - d0, 1);
      chk("xfers", xfers, v.exp_xfers);
      chk("reads", reads, v.exp_reads);
      chk("queue_left", exp_q.size(), 0);
      chk("busy_end", busy, 0);
   endtask

   vec_t tbl[6];
   vec_t rv;
   bit   hit;

   initial begin
      tbl[0] = '{8'h10, 2, 100, 0, 8, 2};
      tbl[1] = '{8'h40, 3, 30, 0, 12, 3};
      tbl[2] = '{8'hFE, 3, 100, 0, 12, 3};
      tbl[3] = '{8'h80, 5, 60, 1, 20, 5};
      tbl[4] = '{8'h00, 1, 50, 0, 4, 1};
      tbl[5] = '{8'h20, 256, 100, 0, 1024, 256};
      for (int i = 0; i < 256; i++)
         mem[i] = {$urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom};
      done_cnt = 0;
      reset = 0;
      start = 0;
      abort = 0;
      base_addr = 0;
      num_rows = 0;
      inst_ready = 0;
      #2;
      chk("rst_rd", mem_rd, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      tick();
      reset = 1;
      tick();

      for (int i = 0; i < 6; i++) run(tbl[i]);

      for (int i = 0; i < 4; i++) begin
         rv.base = 8'($urandom);
         rv.rows = $urandom_range(6, 1);
         rv.pct = $urandom_range(100, 20);
         rv.poke = 0;
         rv.exp_xfers = rv.rows * 4;
         rv.exp_reads = rv.rows;
         run(rv);
      end

      inst_ready = 1;
      do_start(8'h30, 3);
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (inst_valid && inst_slot == 2'd2 && inst_row == 8'h31)
            hit = 1;
         else tick();
      end
      chk("abort_reach", hit, 1);
      abort = 1;
      @(negedge clock);
      #2;
      mon_en = 0;
      @(posedge clock);
      #1;
      abort = 0;
      @(negedge clock);
      chk("abort_valid", inst_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (3) begin
         @(negedge clock);
         chk("abort_v_late", inst_valid, 0);
         chk("abort_d_late", done, 0);
         chk("abort_rd_late", mem_rd, 0);
      end
      tick();
      rv = '{8'hA0, 2, 100, 0, 8, 2};
      run(rv);

      mon_en = 0;
      base_addr = 8'h33;
      num_rows = 9'd0;
      start = 1;
      tick();
      start = 0;
      @(negedge clock);
      chk("zero_done", done, 1);
      chk("zero_rd", mem_rd, 0);
      chk("zero_busy", busy, 0);
      @(negedge clock);
      chk("zero_done2", done, 0);
      chk("zero_rd2", mem_rd, 0);
      tick();

      inst_ready = 1;
      do_start(8'h60, 4);
      repeat (6) tick();
      mon_en = 0;
      active = 0;
      #3;
      reset = 0;
      #1;
      chk("mid_rst_rd", mem_rd, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_valid", inst_valid, 0);
      chk("mid_rst_data", inst_data, 0);
      chk("mid_rst_slot", inst_slot, 0);
      chk("mid_rst_row", inst_row, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      tick();
      reset = 1;
      repeat (3) begin
         @(negedge clock);
         chk("post_rst_rd", mem_rd, 0);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", inst_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
